// File: rtl/uart_apb_driver.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_driver
// Brief    : APB3 requester that configures a CoreUARTapb-style UART and
//            then polls its status register, moving bytes between
//            valid/ready streams and the UART TX/RX data registers.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_driver #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic        BIT8       = 1'b1,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        ODD_N_EVEN = 1'b0,
  parameter int unsigned POLL_GAP   = 0
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [3:0] err_flags,
  input  logic       err_clr,
  output logic       init_done,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  // UART register map
  localparam logic [4:0] c_ADDR_TX    = 5'h00;
  localparam logic [4:0] c_ADDR_RX    = 5'h04;
  localparam logic [4:0] c_ADDR_CTRL1 = 5'h08;
  localparam logic [4:0] c_ADDR_CTRL2 = 5'h0C;
  localparam logic [4:0] c_ADDR_STAT  = 5'h10;

  // Configuration values written once after reset
  localparam logic [7:0] c_CTRL1 = BAUD_VALUE[7:0];
  localparam logic [7:0] c_CTRL2 = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
  localparam logic [7:0] c_GAP   = POLL_GAP[7:0];

  // Top-level FSM: which transfer is being (or will next be) issued
  localparam logic [2:0] c_ST_INIT0 = 3'd0;
  localparam logic [2:0] c_ST_INIT1 = 3'd1;
  localparam logic [2:0] c_ST_GAP   = 3'd2;
  localparam logic [2:0] c_ST_POLL  = 3'd3;
  localparam logic [2:0] c_ST_TXW   = 3'd4;
  localparam logic [2:0] c_ST_RXR   = 3'd5;

  // APB phase within the current transfer; IDLE always precedes SETUP,
  // which guarantees a PSEL=0 cycle between transfers.
  localparam logic [1:0] c_PH_IDLE   = 2'd0;
  localparam logic [1:0] c_PH_SETUP  = 2'd1;
  localparam logic [1:0] c_PH_ACCESS = 2'd2;

  logic [2:0] state_q,    state_d;
  logic [1:0] phase_q,    phase_d;
  logic [7:0] gap_q,      gap_d;
  logic       pref_rx_q,  pref_rx_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic [3:0] err_q,      err_d;
  logic       init_q,     init_d;
  logic [4:0] paddr_q,    paddr_d;
  logic       pwrite_q,   pwrite_d;
  logic [7:0] pwdata_q,   pwdata_d;
  logic       tx_ready_q, tx_ready_d;

  logic       w_tx_ok;
  logic       w_rx_ok;
  logic [2:0] w_after_state;
  logic [7:0] w_after_cnt;

  // Eligibility as seen by a status poll in its completion cycle
  assign w_tx_ok = PRDATA[0] & tx_valid;
  assign w_rx_ok = PRDATA[1] & ~rx_valid_q;

  // After a data/config transfer the FSM waits POLL_GAP cycles, or polls at once
  assign w_after_state = (c_GAP == 8'd0) ? c_ST_POLL : c_ST_GAP;
  assign w_after_cnt   = c_GAP - 8'd1;

  // Next-state logic for the sequencer, APB request fields and stream side
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    gap_d      = gap_q;
    pref_rx_d  = pref_rx_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    init_d     = init_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    tx_ready_d = 1'b0;

    // Clear first so that a same-cycle error below takes precedence
    if (err_clr) begin
      err_d = 4'b0000;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (phase_q)
      c_PH_IDLE: begin
        if (state_q == c_ST_GAP) begin
          if (gap_q == 8'd0) begin
            state_d = c_ST_POLL;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end else begin
          phase_d = c_PH_SETUP;
          case (state_q)
            c_ST_INIT0: begin
              paddr_d  = c_ADDR_CTRL1;
              pwrite_d = 1'b1;
              pwdata_d = c_CTRL1;
            end
            c_ST_INIT1: begin
              paddr_d  = c_ADDR_CTRL2;
              pwrite_d = 1'b1;
              pwdata_d = c_CTRL2;
            end
            c_ST_TXW: begin
              // tx_ready lands in the setup cycle of the TX data write
              paddr_d    = c_ADDR_TX;
              pwrite_d   = 1'b1;
              pwdata_d   = tx_data;
              tx_ready_d = 1'b1;
            end
            c_ST_RXR: begin
              paddr_d  = c_ADDR_RX;
              pwrite_d = 1'b0;
              pwdata_d = 8'h00;
            end
            c_ST_POLL: begin
              paddr_d  = c_ADDR_STAT;
              pwrite_d = 1'b0;
              pwdata_d = 8'h00;
            end
            default: begin
              phase_d = c_PH_IDLE;
              state_d = c_ST_INIT0;
            end
          endcase
        end
      end

      c_PH_SETUP: begin
        phase_d = c_PH_ACCESS;
      end

      c_PH_ACCESS: begin
        if (PREADY) begin
          phase_d = c_PH_IDLE;
          if (PSLVERR) begin
            err_d[3] = 1'b1;
          end
          case (state_q)
            c_ST_INIT0: begin
              state_d = c_ST_INIT1;
            end
            c_ST_INIT1: begin
              init_d  = 1'b1;
              state_d = w_after_state;
              gap_d   = w_after_cnt;
            end
            c_ST_POLL: begin
              err_d[2:0] = err_d[2:0] | PRDATA[4:2];
              // TX wins unless RX is also eligible and it is RX's turn
              if (w_tx_ok && !(w_rx_ok && pref_rx_q)) begin
                state_d   = c_ST_TXW;
                pref_rx_d = 1'b1;
              end else if (w_rx_ok) begin
                state_d   = c_ST_RXR;
                pref_rx_d = 1'b0;
              end else begin
                state_d = w_after_state;
                gap_d   = w_after_cnt;
              end
            end
            c_ST_RXR: begin
              rx_valid_d = 1'b1;
              rx_data_d  = PRDATA;
              state_d    = w_after_state;
              gap_d      = w_after_cnt;
            end
            default: begin
              state_d = w_after_state;
              gap_d   = w_after_cnt;
            end
          endcase
        end
      end

      default: begin
        phase_d = c_PH_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus and any pending rx byte
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= c_ST_INIT0;
      phase_q    <= c_PH_IDLE;
      gap_q      <= 8'd0;
      pref_rx_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      err_q      <= 4'b0000;
      init_q     <= 1'b0;
      paddr_q    <= 5'h00;
      pwrite_q   <= 1'b0;
      pwdata_q   <= 8'h00;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gap_q      <= gap_d;
      pref_rx_q  <= pref_rx_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
      init_q     <= init_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign PSEL      = (phase_q != c_PH_IDLE);
  assign PENABLE   = (phase_q == c_PH_ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign tx_ready  = tx_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign err_flags = err_q;
  assign init_done = init_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_driver
// Brief    : Randomized scoreboard bench for uart_apb_driver. A responder
//            answers APB transfers with random status/data/wait/error; a
//            transaction-level model predicts the transfer sequence, flags,
//            and received bytes, and a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_driver;

  localparam logic [12:0] BAUD      = 13'h1A5;
  localparam int          GAP       = 2;
  localparam logic [7:0]  EXP_CTRL1 = 8'hA5;
  localparam logic [7:0]  EXP_CTRL2 = 8'h09;

  typedef struct packed {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
  } xfer_t;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] err_flags;
  logic       err_clr;
  logic       init_done;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  uart_apb_driver #(
    .BAUD_VALUE (BAUD),
    .BIT8       (1'b1),
    .PARITY_EN  (1'b0),
    .ODD_N_EVEN (1'b0),
    .POLL_GAP   (GAP)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .err_flags (err_flags),
    .err_clr   (err_clr),
    .init_done (init_done),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic [4:0] a, input logic w, input logic [7:0] d);
    xfer_t x;
    x.addr = a;
    x.wr   = w;
    x.data = d;
    return x;
  endfunction

  // Scoreboard and reference model state (written only by the monitor)
  xfer_t      exp_q[$];
  logic [7:0] rxq[$];
  logic [3:0] m_err;
  logic       m_init;
  logic       m_rxfull;
  logic       m_pref_rx;
  int         idle_cnt;
  logic       in_xfer;
  xfer_t      cur;
  int         tx_hs_cnt = 0;
  int         n_xfer = 0;

  // Monitor: predicts and checks at the falling edge
  always @(negedge PCLK) begin : mon
    xfer_t      e;
    logic [3:0] nerr;
    logic [7:0] s;
    logic       tx_ok, rx_ok, rx_set;
    if (PRESET) begin
      chk("reset_outputs",
          {PSEL, PENABLE, PWRITE, tx_ready, rx_valid, init_done, err_flags, PADDR, PWDATA, rx_data},
          32'd0);
      exp_q.delete();
      exp_q.push_back(mk(5'h08, 1'b1, EXP_CTRL1));
      exp_q.push_back(mk(5'h0C, 1'b1, EXP_CTRL2));
      exp_q.push_back(mk(5'h10, 1'b0, 8'h00));
      rxq.delete();
      m_err     = 4'b0;
      m_init    = 1'b0;
      m_rxfull  = 1'b0;
      m_pref_rx = 1'b0;
      idle_cnt  = 0;
      in_xfer   = 1'b0;
    end else begin
      chk("err_flags", err_flags, m_err);
      chk("init_done", init_done, m_init);
      chk("rx_valid", rx_valid, m_rxfull);
      nerr   = err_clr ? 4'b0 : m_err;
      rx_set = 1'b0;
      if (PSEL && !PENABLE) begin
        chk("setup_after_idle", in_xfer, 1'b0);
        if (exp_q.size() == 0) begin
          e = mk(5'h1F, 1'b0, 8'h00);
          chk("unexpected_xfer", PADDR, 5'h1F);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_addr", PADDR, e.addr);
          chk("xfer_write", PWRITE, e.wr);
          if (e.wr) chk("xfer_wdata", PWDATA, e.data);
        end
        chk("idle_gap", idle_cnt, (e.addr == 5'h10) ? GAP + 1 : 1);
        chk("tx_ready_setup", tx_ready, (e.addr == 5'h00) && e.wr);
        cur     = mk(PADDR, PWRITE, PWDATA);
        in_xfer = 1'b1;
      end else if (PSEL && PENABLE) begin
        chk("access_follows_setup", in_xfer, 1'b1);
        chk("access_stable", mk(PADDR, PWRITE, PWDATA), cur);
        chk("tx_ready_access", tx_ready, 1'b0);
        if (PREADY) begin
          if (PSLVERR) nerr[3] = 1'b1;
          case (cur.addr)
            5'h10: begin
              s     = PRDATA;
              nerr[2:0] = nerr[2:0] | s[4:2];
              tx_ok = s[0] && tx_valid;
              rx_ok = s[1] && !m_rxfull;
              if (tx_ok && !(rx_ok && m_pref_rx)) begin
                exp_q.push_back(mk(5'h00, 1'b1, tx_data));
                m_pref_rx = 1'b1;
              end else if (rx_ok) begin
                exp_q.push_back(mk(5'h04, 1'b0, 8'h00));
                m_pref_rx = 1'b0;
              end
              exp_q.push_back(mk(5'h10, 1'b0, 8'h00));
            end
            5'h0C: m_init = 1'b1;
            5'h04: begin
              rxq.push_back(PRDATA);
              rx_set = 1'b1;
            end
            default: ;
          endcase
          in_xfer  = 1'b0;
          idle_cnt = 0;
          n_xfer++;
        end
      end else begin
        chk("bus_held_in_xfer", in_xfer, 1'b0);
        chk("tx_ready_idle", tx_ready, 1'b0);
        idle_cnt++;
        if (idle_cnt > 40) begin
          chk("bus_stalled", idle_cnt, 40);
          idle_cnt = 0;
        end
      end
      if (tx_ready) tx_hs_cnt++;
      if (rx_valid && rx_ready) begin
        if (rxq.size() == 0) chk("rx_unexpected", 1'b1, 1'b0);
        else chk("rx_data", rx_data, rxq.pop_front());
        m_rxfull = 1'b0;
      end
      if (rx_set) m_rxfull = 1'b1;
      m_err = nerr;
    end
  end

  // APB responder and stream-side drivers, updated just after the rising edge
  initial begin : drv
    int   waits;
    logic [7:0] rsp;
    logic rerr;
    int   hs_seen;
    hs_seen  = 0;
    waits    = 0;
    rsp      = 8'h00;
    rerr     = 1'b0;
    PREADY   = 1'b0;
    PRDATA   = 8'h00;
    PSLVERR  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && !PENABLE) begin
        waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        if (PADDR == 5'h10) begin
          rsp = {3'b000,
                 ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000,
                 1'($urandom), 1'($urandom)};
        end else begin
          rsp = 8'($urandom);
        end
        rerr    = ($urandom_range(0, 15) == 0);
        PREADY  = 1'($urandom);
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom);
      end else if (PSEL && PENABLE && waits == 0) begin
        PREADY  = 1'b1;
        PRDATA  = rsp;
        PSLVERR = rerr;
      end else if (PSEL && PENABLE) begin
        waits--;
        PREADY  = 1'b0;
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom);
      end else begin
        PREADY  = 1'($urandom);
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom);
      end
      if (tx_hs_cnt != hs_seen) begin
        hs_seen  = tx_hs_cnt;
        tx_valid = ($urandom_range(0, 3) != 0);
        tx_data  = 8'($urandom);
      end else if (!tx_valid && $urandom_range(0, 3) == 0) begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
      end
      rx_ready = ($urandom_range(0, 2) == 0);
      err_clr  = ($urandom_range(0, 15) == 0);
    end
  end

  // Sequencer: reset, random traffic, reset during a TX data write, more traffic
  initial begin : seq
    logic found;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    repeat (2500) @(posedge PCLK);

    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PWRITE && PADDR == 5'h00) found = 1'b1;
    end
    chk("txw_access_seen", found, 1'b1);
    if (found) begin
      #2 PRESET = 1'b1;
      #1;
      chk("async_reset_bus", {PSEL, PENABLE, rx_valid, tx_ready, init_done}, 5'b0);
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
    end

    repeat (1000) @(posedge PCLK);
    chk("traffic_volume", n_xfer > 200, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
